jtframe_sdram_resp: RTL and testbench
=====================================

Name: jtframe_sdram_resp

Overview:
- Behavioural SDRAM responder: the far end of the ROM-slot request bus and the download write port.
- Answers sdram_req/sdram_addr with sdram_ack, data_dst, data_rdy and data_read, and commits prog_we writes with byte masks.
- Backed by an internal 16-bit word array with programmable CAS latency, burst length and refresh stalls.
- Used in game-level simulation and on small-RAM targets in place of the real SDRAM controller.

Parameters:
- AW, 16, word-address width of the internal array (2^AW x 16 bits); higher address bits ignored.
- CAS, 2, cycles from the sdram_ack cycle to the first data_dst (min 1).
- BURST, 2, 16-bit words returned per read request (1..4).
- REFRESH, 0, if >0, a 4-cycle refresh stall is inserted every REFRESH cycles; 0 disables refresh.

Ports:
- clk, input, 1: single clock.
- rstn, input, 1: asynchronous, active-low reset.
- downloading, input, 1: while high, reads are not serviced.
- prog_we, input, 1: write request, held until sdram_ack.
- prog_addr, input, 22: word address of the write.
- prog_data, input, 8: byte written to each enabled lane.
- prog_mask, input, 2: active-low byte enables; bit0 = [7:0], bit1 = [15:8].
- sdram_req, input, 1: read request, level, held until sdram_ack.
- sdram_addr, input, 22: word address of the read burst.
- sdram_ack, output, 1: one-cycle acceptance pulse for a read or a write.
- data_dst, output, 1: one-cycle pulse per returned word.
- data_rdy, output, 1: one-cycle pulse coincident with the last data_dst of a burst.
- data_read, output, 16: word valid while data_dst is high.

Behaviour:
- Reset: sdram_ack, data_dst, data_rdy and data_read are 0; FSM goes to IDLE; counters are 0. Array contents are not cleared.
- Reset asserted mid-operation aborts the operation: no further pulses, and a partial write is not committed.
- FSM states: IDLE, WR, CASW, BURST, RFSH.
- IDLE arbitration, in priority order:
  - Refresh due -> RFSH.
  - Else prog_we high -> WR.
  - Else sdram_req high and downloading low -> CASW.
  - With prog_we and sdram_req both high, the write wins; the read is taken on a later IDLE cycle.
- WR (1 cycle):
  - Writes {prog_data, prog_data} under ~prog_mask to addr prog_addr[AW-1:0].
  - Pulses sdram_ack, then returns to IDLE.
  - The next write can be accepted no earlier than 2 cycles after the previous one.
- Read acceptance:
  - The IDLE->CASW transition latches sdram_addr and pulses sdram_ack in the first CASW cycle.
  - CASW lasts CAS cycles, so the first data_dst occurs CAS cycles after the ack.
- BURST:
  - BURST consecutive cycles with data_dst=1; word i = mem[(latched_addr+i) mod 2^AW]. Linear increment, wrapping at the array end.
  - data_rdy=1 on the last word only, then return to IDLE.
- Read-during-write is impossible: a single FSM serialises reads and writes.
- data_read holds its last value outside data_dst pulses.
- A requester dropping sdram_req after ack has no effect on a burst in flight.
- sdram_req still high on the IDLE cycle after data_rdy starts a new read.
- Refresh:
  - Free-running counter wraps at REFRESH-1 and sets a pending flag.
  - The flag is honoured only in IDLE; RFSH lasts 4 cycles and then clears the flag.
  - Requests arriving during RFSH wait.
- downloading rising mid-burst: the burst completes normally.

Decomposition:
- Package jtframe_sdram_resp_pkg holds:
  - the state enum (IDLE, WR, CASW, BURST, RFSH);
  - the refresh stall length constant (4);
  - the maximum BURST constant (4).
- Sub-module jtframe_sdram_resp_mem: single-port 2^AW x 16 RAM with per-byte write enables and registered read data. The read address is issued one cycle ahead so the output aligns with data_dst.

Test Plan:
- Write then read: prog_we at addr 0x000010, data 0xA5, mask 2'b00 -> ack 1 cycle later; then read of 0x10 with CAS=2, BURST=2 -> ack, 2 cycles gap, data_read 0xA5A5 with dst, then the next word with dst+rdy.
- Masked write: pre-load 0x1234 at addr 5, write 0xFF with mask 2'b10 -> readback 0x12FF; with mask 2'b01 -> 0xFF34.
- Arbitration: prog_we and sdram_req rise on the same cycle with downloading=0 -> write ack first, then read ack ≥2 cycles later; while downloading=1, sdram_req is never acked.
- Wrap: AW=4, read at addr 15 with BURST=2 -> words mem[15] then mem[0], data_rdy on the second word.
- Refresh: REFRESH=16 with continuous back-to-back reads -> a 4-cycle gap with no ack appears every ~16 cycles; no request is lost and data stays correct.
- Reset mid-burst: drop rstn during the first data_dst -> all outputs 0 immediately; after release, sdram_req is honoured with the full CAS latency.

Source files
------------

// File: rtl/jtframe_sdram_resp_pkg.sv
// Shared types and constants for the behavioural SDRAM responder.
package jtframe_sdram_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_CASW  = 3'd2,
    ST_BURST = 3'd3,
    ST_RFSH  = 3'd4
  } state_t;

  localparam int unsigned RFSH_LEN  = 4;
  localparam int unsigned BURST_MAX = 4;

endpackage

// File: rtl/jtframe_sdram_resp_mem.sv
// Single-port 16-bit word RAM with byte enables and registered read data.
module jtframe_sdram_resp_mem
  import jtframe_sdram_resp_pkg::*;
#(
  parameter int unsigned AW = 16
)(
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [1:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  input  logic          rd,
  output logic [15:0]   q
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [15:0] r_mem [DEPTH];
  logic [15:0] r_q;

  // Byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      if (be[0]) r_mem[addr][7:0]  <= wdata[7:0];
      if (be[1]) r_mem[addr][15:8] <= wdata[15:8];
    end
  end

  // Read register only updates on a read strobe so the last word is held.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   r_q <= '0;
    else if (rd) r_q <= r_mem[addr];
  end

  assign q = r_q;

endmodule

// File: rtl/jtframe_sdram_resp.sv
// Behavioural SDRAM responder: serves ROM-slot reads and download writes.
module jtframe_sdram_resp
  import jtframe_sdram_resp_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned CAS     = 2,
  parameter int unsigned BURST   = 2,
  parameter int unsigned REFRESH = 0
)(
  input  logic        clk,
  input  logic        rstn,
  input  logic        downloading,
  input  logic        prog_we,
  input  logic [21:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic [1:0]  prog_mask,
  input  logic        sdram_req,
  input  logic [21:0] sdram_addr,
  output logic        sdram_ack,
  output logic        data_dst,
  output logic        data_rdy,
  output logic [15:0] data_read
);

  localparam int unsigned CW  = 8;
  localparam int unsigned CL  = (CAS < 1) ? 1 : CAS;
  localparam int unsigned BL  = (BURST < 1) ? 1 : ((BURST > BURST_MAX) ? BURST_MAX : BURST);
  localparam int unsigned RCW = (REFRESH > 1) ? $clog2(REFRESH) : 1;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_raddr, r_waddr;
  logic [7:0]    r_wdata;
  logic [1:0]    r_wmask;
  logic          r_ack, r_dst, r_rdy, r_pend;
  logic          w_ack_nxt, w_dst_nxt, w_rdy_nxt, w_rfsh_done, w_rwrap;
  logic          w_mem_we, w_mem_rd;
  logic [AW-1:0] w_mem_addr, w_rd_off;
  logic [15:0]   w_mem_q;
  logic          w_unused_addr;

  // Upper address bits beyond the array are deliberately ignored.
  assign w_unused_addr = ^{prog_addr, sdram_addr};

  // Next-state and next-output decode.
  always_comb begin
    w_next      = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = 1'b0;
    w_rfsh_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (r_pend) begin
          w_next = ST_RFSH;
        end else if (prog_we) begin
          w_next    = ST_WR;
          w_ack_nxt = 1'b1;
        end else if (sdram_req && !downloading) begin
          w_next    = ST_CASW;
          w_ack_nxt = 1'b1;
        end
      end
      ST_WR: begin
        w_next = ST_IDLE;
      end
      ST_CASW: begin
        if (r_cnt == CW'(CL - 1)) begin
          w_next    = ST_BURST;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_BURST: begin
        if (r_cnt == CW'(BL - 1)) begin
          w_next    = ST_IDLE;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_RFSH: begin
        if (r_cnt == CW'(RFSH_LEN - 1)) begin
          w_next      = ST_IDLE;
          w_cnt_nxt   = '0;
          w_rfsh_done = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_next    = ST_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  // Data strobes are registered, so decode them from the upcoming state.
  assign w_dst_nxt = (w_next == ST_BURST);
  assign w_rdy_nxt = w_dst_nxt && (w_cnt_nxt == CW'(BL - 1));

  // State, counters, latched request fields and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_raddr <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_ack   <= 1'b0;
      r_dst   <= 1'b0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_ack_nxt;
      r_dst   <= w_dst_nxt;
      r_rdy   <= w_rdy_nxt;
      if (r_state == ST_IDLE && w_next == ST_CASW) r_raddr <= sdram_addr[AW-1:0];
      if (r_state == ST_IDLE && w_next == ST_WR) begin
        r_waddr <= prog_addr[AW-1:0];
        r_wdata <= prog_data;
        r_wmask <= prog_mask;
      end
    end
  end

  // Free-running refresh timer; only present when refresh is enabled.
  if (REFRESH > 0) begin : g_rfsh
    logic [RCW-1:0] r_rcnt;
    assign w_rwrap = (r_rcnt == RCW'(REFRESH - 1));
    // Timer wraps at REFRESH-1.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)        r_rcnt <= '0;
      else if (w_rwrap) r_rcnt <= '0;
      else              r_rcnt <= r_rcnt + RCW'(1);
    end
  end else begin : g_no_rfsh
    assign w_rwrap = 1'b0;
  end

  // Pending refresh flag: set on timer wrap, cleared when the stall ends.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            r_pend <= 1'b0;
    else if (w_rwrap)     r_pend <= 1'b1;
    else if (w_rfsh_done) r_pend <= 1'b0;
  end

  // Read address runs one word ahead of data_dst.
  assign w_rd_off   = (r_state == ST_BURST) ? AW'(r_cnt + CW'(1)) : '0;
  assign w_mem_we   = (r_state == ST_WR);
  assign w_mem_rd   = w_dst_nxt;
  assign w_mem_addr = w_mem_we ? r_waddr : (r_raddr + w_rd_off);

  jtframe_sdram_resp_mem #(.AW(AW)) u_mem (
    .clk   (clk),
    .rstn  (rstn),
    .we    (w_mem_we),
    .be    (~r_wmask),
    .addr  (w_mem_addr),
    .wdata ({r_wdata, r_wdata}),
    .rd    (w_mem_rd),
    .q     (w_mem_q)
  );

  assign sdram_ack = r_ack;
  assign data_dst  = r_dst;
  assign data_rdy  = r_rdy;
  assign data_read = w_mem_q;

endmodule

// File: tb/tb_jtframe_sdram_resp.sv
// Directed bench: dut 0 (no refresh) for function, dut 1 (REFRESH=16) for stalls.
module tb_jtframe_sdram_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        downloading [2];
  logic        prog_we     [2];
  logic [21:0] prog_addr   [2];
  logic [7:0]  prog_data   [2];
  logic [1:0]  prog_mask   [2];
  logic        sdram_req   [2];
  logic [21:0] sdram_addr  [2];
  logic        sdram_ack   [2];
  logic        data_dst    [2];
  logic        data_rdy    [2];
  logic [15:0] data_read   [2];

  int n_tests = 0;
  int n_fail  = 0;

  jtframe_sdram_resp #(.AW(4), .CAS(2), .BURST(2), .REFRESH(0)) dut0 (
    .clk(clk), .rstn(rstn), .downloading(downloading[0]), .prog_we(prog_we[0]),
    .prog_addr(prog_addr[0]), .prog_data(prog_data[0]), .prog_mask(prog_mask[0]),
    .sdram_req(sdram_req[0]), .sdram_addr(sdram_addr[0]), .sdram_ack(sdram_ack[0]),
    .data_dst(data_dst[0]), .data_rdy(data_rdy[0]), .data_read(data_read[0])
  );

  jtframe_sdram_resp #(.AW(4), .CAS(2), .BURST(2), .REFRESH(16)) dut1 (
    .clk(clk), .rstn(rstn), .downloading(downloading[1]), .prog_we(prog_we[1]),
    .prog_addr(prog_addr[1]), .prog_data(prog_data[1]), .prog_mask(prog_mask[1]),
    .sdram_req(sdram_req[1]), .sdram_addr(sdram_addr[1]), .sdram_ack(sdram_ack[1]),
    .data_dst(data_dst[1]), .data_rdy(data_rdy[1]), .data_read(data_read[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue a write and wait for its ack; exp_lat<=0 skips the latency check.
  task automatic do_write(input int d, input logic [21:0] a, input logic [7:0] v,
                          input logic [1:0] m, input int exp_lat, input string tag);
    int lat;
    lat = 0;
    prog_we[d] = 1'b1; prog_addr[d] = a; prog_data[d] = v; prog_mask[d] = m;
    do begin @(negedge clk); lat++; end while (!sdram_ack[d] && lat < 40);
    prog_we[d] = 1'b0;
    chk({tag, "_ack"}, 32'(sdram_ack[d]), 32'd1);
    if (exp_lat > 0) chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  // Issue a BURST=2, CAS=2 read on dut 0 and check its pulse timing.
  task automatic do_read(input logic [21:0] a, input int exp_lat, input string tag,
                         output logic [15:0] w0, output logic [15:0] w1);
    int lat;
    lat = 0;
    sdram_req[0] = 1'b1; sdram_addr[0] = a;
    do begin @(negedge clk); lat++; end while (!sdram_ack[0] && lat < 40);
    sdram_req[0] = 1'b0;
    chk({tag, "_ack"}, 32'(sdram_ack[0]), 32'd1);
    chk({tag, "_acklat"}, 32'(lat), 32'(exp_lat));
    lat = 0;
    do begin @(negedge clk); lat++; end while (!data_dst[0] && lat < 20);
    chk({tag, "_caslat"}, 32'(lat), 32'd2);
    chk({tag, "_rdy0"}, 32'(data_rdy[0]), 32'd0);
    w0 = data_read[0];
    @(negedge clk);
    chk({tag, "_dst1"}, 32'(data_dst[0]), 32'd1);
    chk({tag, "_rdy1"}, 32'(data_rdy[0]), 32'd1);
    w1 = data_read[0];
    @(negedge clk);
    chk({tag, "_dst_end"}, 32'(data_dst[0]), 32'd0);
    chk({tag, "_hold"}, 32'(data_read[0]), 32'(w1));
  endtask

  initial begin
    logic [15:0] w0, w1;
    int cnt;
    int acks, dsts, rdys, bad_data, bad_gap, long_gap, last_ack, idx;

    rstn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      downloading[d] = 1'b0; prog_we[d] = 1'b0; prog_addr[d] = '0; prog_data[d] = '0;
      prog_mask[d] = '0; sdram_req[d] = 1'b0; sdram_addr[d] = '0;
    end
    cyc(3);
    chk("rst_ack",  32'(sdram_ack[0]), 32'd0);
    chk("rst_dst",  32'(data_dst[0]),  32'd0);
    chk("rst_rdy",  32'(data_rdy[0]),  32'd0);
    chk("rst_data", 32'(data_read[0]), 32'd0);
    rstn = 1'b1;
    cyc(1);

    // Write then read; upper address bits are ignored (0x10 -> word 0).
    do_write(0, 22'h000010, 8'hA5, 2'b00, 1, "wr0");
    do_write(0, 22'h000011, 8'h3C, 2'b00, 2, "wr_b2b");
    cyc(1);
    do_read(22'h000010, 1, "rd0", w0, w1);
    chk("rd0_w0", 32'(w0), 32'h0000A5A5);
    chk("rd0_w1", 32'(w1), 32'h00003C3C);

    // Byte-masked writes.
    do_write(0, 22'h5, 8'h34, 2'b10, 1, "pre_lo");
    do_write(0, 22'h5, 8'h12, 2'b01, 2, "pre_hi");
    do_write(0, 22'h5, 8'hFF, 2'b10, 2, "mask10");
    cyc(1);
    do_read(22'h5, 1, "rd_m10", w0, w1);
    chk("mask10_w0", 32'(w0), 32'h000012FF);
    do_write(0, 22'h5, 8'h34, 2'b10, 1, "re_lo");
    do_write(0, 22'h5, 8'hFF, 2'b01, 2, "mask01");
    cyc(1);
    do_read(22'h5, 1, "rd_m01", w0, w1);
    chk("mask01_w0", 32'(w0), 32'h0000FF34);

    // Simultaneous write and read: write first, read two cycles later.
    prog_we[0] = 1'b1; prog_addr[0] = 22'h7; prog_data[0] = 8'h66; prog_mask[0] = 2'b00;
    sdram_req[0] = 1'b1; sdram_addr[0] = 22'h7;
    @(negedge clk);
    chk("arb_wr_ack", 32'(sdram_ack[0]), 32'd1);
    prog_we[0] = 1'b0;
    @(negedge clk);
    chk("arb_gap", 32'(sdram_ack[0]), 32'd0);
    @(negedge clk);
    chk("arb_rd_ack", 32'(sdram_ack[0]), 32'd1);
    sdram_req[0] = 1'b0;
    cyc(2);
    chk("arb_rd_dst",  32'(data_dst[0]),  32'd1);
    chk("arb_rd_data", 32'(data_read[0]), 32'h00006666);
    cyc(2);

    // Reads are ignored while downloading.
    downloading[0] = 1'b1; sdram_req[0] = 1'b1; sdram_addr[0] = 22'h0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sdram_ack[0]) cnt++;
    end
    chk("dl_no_ack", 32'(cnt), 32'd0);
    sdram_req[0] = 1'b0; downloading[0] = 1'b0;
    cyc(1);

    // Burst wraps at the array end: mem[15] then mem[0].
    do_write(0, 22'h00000F, 8'h5A, 2'b00, 1, "wr_wrap");
    cyc(1);
    do_read(22'h00000F, 1, "rd_wrap", w0, w1);
    chk("wrap_w0", 32'(w0), 32'h00005A5A);
    chk("wrap_w1", 32'(w1), 32'h0000A5A5);

    // Reset during the first data word aborts the burst.
    sdram_req[0] = 1'b1; sdram_addr[0] = 22'h0;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!sdram_ack[0] && cnt < 40);
    sdram_req[0] = 1'b0;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!data_dst[0] && cnt < 20);
    chk("mr_dst_seen", 32'(data_dst[0]), 32'd1);
    rstn = 1'b0;
    #1;
    chk("mr_ack",  32'(sdram_ack[0]), 32'd0);
    chk("mr_dst",  32'(data_dst[0]),  32'd0);
    chk("mr_rdy",  32'(data_rdy[0]),  32'd0);
    chk("mr_data", 32'(data_read[0]), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (data_dst[0] || data_rdy[0] || sdram_ack[0]) cnt++;
    end
    chk("mr_quiet", 32'(cnt), 32'd0);
    do_read(22'h0, 1, "rd_after_rst", w0, w1);
    chk("after_rst_w0", 32'(w0), 32'h0000A5A5);
    chk("after_rst_w1", 32'(w1), 32'h00003C3C);

    // Refresh stalls on dut 1 under back-to-back reads.
    do_write(1, 22'h3, 8'h22, 2'b10, 0, "r_lo");
    do_write(1, 22'h3, 8'h11, 2'b01, 0, "r_hi");
    do_write(1, 22'h4, 8'h7E, 2'b00, 0, "r_w4");
    cyc(1);
    acks = 0; dsts = 0; rdys = 0; bad_data = 0; bad_gap = 0; long_gap = 0;
    last_ack = -1; idx = 0;
    sdram_req[1] = 1'b1; sdram_addr[1] = 22'h3;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (data_dst[1]) begin
        if (data_read[1] !== ((idx == 1) ? 16'h7E7E : 16'h1122)) bad_data++;
        if (data_rdy[1] !== (idx == 1)) bad_data++;
        dsts++;
        if (data_rdy[1]) rdys++;
        idx = idx ^ 1;
      end else if (data_rdy[1]) begin
        bad_data++;
      end
      if (sdram_ack[1]) begin
        if (last_ack >= 0) begin
          if (t - last_ack == 10) long_gap++;
          else if (t - last_ack != 5) bad_gap++;
        end
        last_ack = t;
        acks++;
        if (acks == 20) sdram_req[1] = 1'b0;
      end
      if (acks == 20 && t - last_ack >= 8) break;
    end
    chk("rf_acks",     32'(acks),     32'd20);
    chk("rf_dsts",     32'(dsts),     32'd40);
    chk("rf_rdys",     32'(rdys),     32'd20);
    chk("rf_bad_data", 32'(bad_data), 32'd0);
    chk("rf_bad_gap",  32'(bad_gap),  32'd0);
    chk("rf_stalls",   32'(long_gap >= 4), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
